// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester ports plus the single-port memory side.
// Latency: none; this is wiring only.
// Backpressure: requesters hold req/addr/data stable until their gnt is seen.
interface mem_port_arbiter_if;

    // requester 0
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wr_data;
    logic        m0_wr_ena;
    logic        m0_gnt;
    logic        m0_rd_valid;

    // requester 1
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wr_data;
    logic        m1_wr_ena;
    logic        m1_gnt;
    logic        m1_rd_valid;

    // shared read return
    logic [31:0] rd_data;

    // single-port memory
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ena;
    logic [31:0] mem_rd_data;

    // arbiter side
    modport slave (
        input  m0_req, m0_addr, m0_wr_data, m0_wr_ena,
        input  m1_req, m1_addr, m1_wr_data, m1_wr_ena,
        input  mem_rd_data,
        output m0_gnt, m0_rd_valid,
        output m1_gnt, m1_rd_valid,
        output rd_data,
        output mem_addr, mem_wr_data, mem_wr_ena
    );

    // requester / memory model side
    modport master (
        output m0_req, m0_addr, m0_wr_data, m0_wr_ena,
        output m1_req, m1_addr, m1_wr_data, m1_wr_ena,
        output mem_rd_data,
        input  m0_gnt, m0_rd_valid,
        input  m1_gnt, m1_rd_valid,
        input  rd_data,
        input  mem_addr, mem_wr_data, mem_wr_ena
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port memory with bounded-hold fairness.
// Latency: grant and memory drive are combinational; read valid one cycle after a read grant.
// Backpressure: an ungranted requester keeps its request up; nothing is buffered here.
module mem_port_arbiter #(
    // Longest run of grants to one requester while the other waits (1..15).
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    // Registered arbitration history. last_owner: 0 = m0, 1 = m1.
    logic       last_owner;
    logic       prev_granted;
    logic [3:0] hold_cnt;
    logic       m0_rd_valid_q;
    logic       m1_rd_valid_q;

    logic       last_owner_nxt;
    logic       prev_granted_nxt;
    logic [3:0] hold_cnt_nxt;

    logic       gnt0;
    logic       gnt1;
    logic       gnt_any;
    logic       gnt_id;
    logic       same_owner_run;

    // Grant decision: a lone requester always wins; under contention the
    // previous owner keeps the port until its run reaches HOLD_MAX.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            if (prev_granted && (hold_cnt < HOLD_MAX)) begin
                gnt0 = ~last_owner;
                gnt1 = last_owner;
            end else begin
                gnt0 = last_owner;
                gnt1 = ~last_owner;
            end
        end else begin
            gnt0 = bus.m0_req;
            gnt1 = bus.m1_req;
        end
    end

    assign gnt_any        = gnt0 | gnt1;
    assign gnt_id         = gnt1;
    assign same_owner_run = prev_granted && (last_owner == gnt_id);

    // Next arbitration history: grants extend or restart the run, idle cycles clear it.
    always_comb begin
        last_owner_nxt   = last_owner;
        prev_granted_nxt = 1'b0;
        hold_cnt_nxt     = 4'd0;
        if (gnt_any) begin
            last_owner_nxt   = gnt_id;
            prev_granted_nxt = 1'b1;
            if (same_owner_run) begin
                hold_cnt_nxt = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 4'd1;
            end else begin
                hold_cnt_nxt = 4'd1;
            end
        end
    end

    // State register; reset makes m0 the first winner of a contended cycle
    // and drops any read-valid already in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner    <= 1'b1;
            prev_granted  <= 1'b0;
            hold_cnt      <= 4'd0;
            m0_rd_valid_q <= 1'b0;
            m1_rd_valid_q <= 1'b0;
        end else begin
            last_owner    <= last_owner_nxt;
            prev_granted  <= prev_granted_nxt;
            hold_cnt      <= hold_cnt_nxt;
            m0_rd_valid_q <= gnt0 & ~bus.m0_wr_ena;
            m1_rd_valid_q <= gnt1 & ~bus.m1_wr_ena;
        end
    end

    // Memory drive: the granted requester's access goes out this cycle; idle drives zeros.
    always_comb begin
        bus.mem_addr    = 32'd0;
        bus.mem_wr_data = 32'd0;
        bus.mem_wr_ena  = 1'b0;
        if (gnt0) begin
            bus.mem_addr    = bus.m0_addr;
            bus.mem_wr_data = bus.m0_wr_data;
            bus.mem_wr_ena  = bus.m0_wr_ena;
        end else if (gnt1) begin
            bus.mem_addr    = bus.m1_addr;
            bus.mem_wr_data = bus.m1_wr_data;
            bus.mem_wr_ena  = bus.m1_wr_ena;
        end
    end

    assign bus.m0_gnt      = gnt0;
    assign bus.m1_gnt      = gnt1;
    assign bus.m0_rd_valid = m0_rd_valid_q;
    assign bus.m1_rd_valid = m1_rd_valid_q;
    // Memory has one-cycle read latency, which lines up with rd_valid.
    assign bus.rd_data     = bus.mem_rd_data;

endmodule
